// File: rtl/rng_pkg.sv
// -----------------------------------------------------------------------------
// rng_pkg
// Shared constants and types for the RNG sample path.
//   RNG_W             generator sample width; the buffer's DATA_W must match it
//   RNG_DEPTH_DEFAULT default number of sample FIFO entries (power of two)
//   RNG_OVF_W_DEFAULT default width of the saturating overflow counter
//   rng_sample_t      one raw generator sample
// -----------------------------------------------------------------------------
package rng_pkg;

    localparam int RNG_W             = 16;
    localparam int RNG_DEPTH_DEFAULT = 8;
    localparam int RNG_OVF_W_DEFAULT = 16;

    typedef logic [RNG_W-1:0] rng_sample_t;

endpackage : rng_pkg

// File: rtl/rng_sync_fifo.sv
// -----------------------------------------------------------------------------
// rng_sync_fifo
// Single-clock first-word-fall-through FIFO holding raw RNG samples.
// DEPTH must be a power of two (2..256) so the pointers wrap naturally.
// The occupancy is held in its own register (0..DEPTH) rather than being
// derived from the pointers.
//
// Ports
//   clk_in     input   clock
//   rst_n      input   synchronous active-low reset
//   push       input   write request; ignored when full unless a pop is
//                      accepted in the same cycle
//   push_data  input   [DATA_W] data written on an accepted push
//   pop        input   read request; ignored when empty
//   head       output  [DATA_W] entry at the read pointer
//   full       output  count == DEPTH
//   empty      output  count == 0
//   count      output  [clog2(DEPTH)+1] current number of entries
// -----------------------------------------------------------------------------
module rng_sync_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH  = RNG_DEPTH_DEFAULT,
    parameter int DATA_W = RNG_W
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the full FIFO needs.
    assign do_push = push & (~full | do_pop);

    // Always reads the array, so the head is a defined value even when empty.
    assign head = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Contents are cleared only so an empty head never reads as X.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : rng_sync_fifo

// File: rtl/rng_sample_buffer.sv
// -----------------------------------------------------------------------------
// rng_sample_buffer
// Captures one sample per rising edge of the generator's ready level into a
// small FIFO and presents it on a valid/ready stream. Samples arriving while
// the FIFO is full are dropped and counted in a saturating counter.
//
// Build option
//   RNG_RANGE_EN  when defined, adds range_in and maps the head into
//                 [0, range_in) with a multiply-shift; the FIFO keeps raw
//                 samples. When undefined, out_data is the raw head.
//
// Ports
//   clk_in        input   clock shared with the generator
//   rst_n         input   synchronous active-low reset
//   rng_data_in   input   [DATA_W] generator sample, stable while ready high
//   rng_ready_in  input   generator ready level; rising edge = new sample
//   range_in      input   [DATA_W] mapping range (RNG_RANGE_EN only)
//   out_data      output  [DATA_W] FIFO head (first-word-fall-through)
//   out_valid     output  FIFO not empty
//   out_ready     input   consumer takes out_data this cycle
//   fill_level    output  [clog2(DEPTH)+1] entries currently held
//   overflow_cnt  output  [OVF_W] dropped samples, saturating
// -----------------------------------------------------------------------------
module rng_sample_buffer
    import rng_pkg::*;
#(
    parameter int DEPTH  = RNG_DEPTH_DEFAULT,
    parameter int DATA_W = RNG_W,
    parameter int OVF_W  = RNG_OVF_W_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        rng_data_in,
    input  logic                     rng_ready_in,
`ifdef RNG_RANGE_EN
    input  logic [DATA_W-1:0]        range_in,
`endif
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [OVF_W-1:0]         overflow_cnt
);

    logic [DATA_W-1:0] data_q;
    logic              rdy_q;
    logic              rdy_qq;
    logic              capture;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    // Ready history resets high so a level already high at reset release is
    // not mistaken for a fresh sample.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            data_q <= '0;
            rdy_q  <= 1'b1;
            rdy_qq <= 1'b1;
        end else begin
            data_q <= rng_data_in;
            rdy_q  <= rng_ready_in;
            rdy_qq <= rdy_q;
        end
    end

    assign capture = rdy_q & ~rdy_qq;
    assign pop     = out_valid & out_ready;
    assign drop    = capture & fifo_full & ~pop;

    rng_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (data_q),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill_level)
    );

    assign out_valid = ~fifo_empty;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
        end else if (drop && (overflow_cnt != '1)) begin
            overflow_cnt <= overflow_cnt + OVF_W'(1);
        end
    end

`ifdef RNG_RANGE_EN
    // Upper half of the full-width product lands in [0, range_in).
    logic [2*DATA_W-1:0] range_prod;

    assign range_prod = {{DATA_W{1'b0}}, head} * {{DATA_W{1'b0}}, range_in};
    assign out_data   = range_prod[2*DATA_W-1:DATA_W];
`else
    assign out_data = head;
`endif

endmodule : rng_sample_buffer

// File: tb/tb_rng_sample_buffer.sv
module tb_rng_sample_buffer;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;
    localparam int OVF_W  = 16;
    localparam int FW     = $clog2(DEPTH) + 1;

    logic              clk_in = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rng_data_in;
    logic              rng_ready_in;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [FW-1:0]     fill_level;
    logic [OVF_W-1:0]  overflow_cnt;
`ifdef RNG_RANGE_EN
    logic [DATA_W-1:0] range_in;
`endif

    always #5 clk_in = ~clk_in;

    rng_sample_buffer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .OVF_W  (OVF_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .rng_data_in  (rng_data_in),
        .rng_ready_in (rng_ready_in),
`ifdef RNG_RANGE_EN
        .range_in     (range_in),
`endif
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fill_level   (fill_level),
        .overflow_cnt (overflow_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic [15:0] data;
        logic        ordy;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [3:0]  exp_fill;
        logic [15:0] exp_ovf;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected visible value of a raw head under the current build.
    function automatic logic [15:0] exp_out(input logic [15:0] raw);
`ifdef RNG_RANGE_EN
        logic [31:0] p;
        p = {16'h0, raw} * {16'h0, range_in};
        return p[31:16];
`else
        return raw;
`endif
    endfunction

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Ready low for one sampled cycle, then high with the sample. The push
    // itself lands on the following edge.
    task automatic capture_one(input logic [15:0] d);
        rng_ready_in = 1'b0;
        step();
        rng_ready_in = 1'b1;
        rng_data_in  = d;
        step();
    endtask

    initial begin
        //           rst  rdy  data      ordy  valid exp_data fill ovf
        vecs[0]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[2]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[3]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[4]  = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[5]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[6]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234, 4'd1, 16'd0};
        vecs[7]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h1234, 4'd1, 16'd0};
        vecs[8]  = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[9]  = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[10] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 4'd1, 16'd0};
        vecs[11] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[12] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[13] = '{1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[14] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[15] = '{1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 4'd0, 16'd0};
        vecs[16] = '{1'b1, 1'b0, 16'h0011, 1'b0, 1'b1, 16'h0011, 4'd1, 16'd0};
        vecs[17] = '{1'b1, 1'b1, 16'h0022, 1'b0, 1'b1, 16'h0011, 4'd1, 16'd0};
        vecs[18] = '{1'b1, 1'b0, 16'h0022, 1'b1, 1'b1, 16'h0022, 4'd1, 16'd0};
        vecs[19] = '{1'b1, 1'b0, 16'h0022, 1'b1, 1'b0, 16'h0000, 4'd0, 16'd0};

        rst_n        = 1'b0;
        rng_ready_in = 1'b1;
        rng_data_in  = 16'h1234;
        out_ready    = 1'b0;
`ifdef RNG_RANGE_EN
        range_in     = 16'hFFFF;
`endif

        // Reset release with ready high, single capture, held-high ready,
        // and simultaneous push/pop on a non-empty FIFO.
        for (int i = 0; i < NVEC; i++) begin
            rst_n        = vecs[i].rst_n;
            rng_ready_in = vecs[i].rdy;
            rng_data_in  = vecs[i].data;
            out_ready    = vecs[i].ordy;
            step();
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d fill", i), 32'(fill_level), 32'(vecs[i].exp_fill));
            check($sformatf("vec%0d ovf", i), 32'(overflow_cnt), 32'(vecs[i].exp_ovf));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d data", i), 32'(out_data), 32'(exp_out(vecs[i].exp_data)));
            end
        end

        // Overflow: 10 captures into an 8-deep FIFO with no consumer.
        rst_n        = 1'b0;
        rng_ready_in = 1'b0;
        out_ready    = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            capture_one(16'(i));
        end
        rng_ready_in = 1'b0;
        step();
        check("ovf fill", 32'(fill_level), 32'd8);
        check("ovf count", 32'(overflow_cnt), 32'd2);
        check("ovf valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            check($sformatf("drain%0d data", j), 32'(out_data), 32'(exp_out(16'(j))));
            check($sformatf("drain%0d valid", j), 32'(out_valid), 32'd1);
            step();
        end
        check("drain empty valid", 32'(out_valid), 32'd0);
        check("drain empty fill", 32'(fill_level), 32'd0);
        check("drain ovf held", 32'(overflow_cnt), 32'd2);
        out_ready = 1'b0;

        // Full FIFO: capture and pop in the same cycle.
        for (int i = 1; i <= 8; i++) begin
            capture_one(16'h0100 + 16'(i));
        end
        rng_ready_in = 1'b0;
        step();
        check("full fill", 32'(fill_level), 32'd8);
        capture_one(16'h0999);
        rng_ready_in = 1'b0;
        out_ready    = 1'b1;
        step();
        check("full pushpop fill", 32'(fill_level), 32'd8);
        check("full pushpop ovf", 32'(overflow_cnt), 32'd2);
        check("full pushpop head", 32'(out_data), 32'(exp_out(16'h0102)));
        for (int j = 0; j < 8; j++) begin
            check($sformatf("fullq%0d data", j), 32'(out_data),
                  32'(exp_out((j < 7) ? 16'h0102 + 16'(j) : 16'h0999)));
            step();
        end
        check("fullq empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Reset with 5 entries queued and one capture in flight.
        for (int i = 1; i <= 5; i++) begin
            capture_one(16'h0200 + 16'(i));
        end
        rng_ready_in = 1'b0;
        step();
        check("mid fill", 32'(fill_level), 32'd5);
        rng_ready_in = 1'b1;
        rng_data_in  = 16'h02FF;
        step();
        rst_n = 1'b0;
        step();
        check("rst fill", 32'(fill_level), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst ovf", 32'(overflow_cnt), 32'd0);
        rst_n        = 1'b1;
        rng_ready_in = 1'b0;
        step();
        step();
        check("post rst fill", 32'(fill_level), 32'd0);
        check("post rst valid", 32'(out_valid), 32'd0);

`ifdef RNG_RANGE_EN
        capture_one(16'h8000);
        rng_ready_in = 1'b0;
        step();
        range_in = 16'd10;
        #1;
        check("range 10", 32'(out_data), 32'd5);
        range_in = 16'd0;
        #1;
        check("range 0", 32'(out_data), 32'd0);
        range_in  = 16'hFFFF;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("range drained", 32'(out_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rng_sample_buffer
